// File: rtl/controlador_pilha_if.sv
// -----------------------------------------------------------------------------
// controlador_pilha_if
// Datapath-side bundle of the stack controller. The requester uses the master
// modport and the controller uses the slave modport.
//   push/pop/din (peek) : request side, sampled by the controller only in IDLE
//   ready               : controller can take a request this cycle
//   dout/dout_valid     : popped (or peeked) word, one-cycle valid pulse
//   full/empty/count    : occupancy status
//   overflow/underflow  : sticky error flags, cleared only by reset
// Optional macro PILHA_PEEK_EN adds the 'peek' request signal.
// -----------------------------------------------------------------------------
interface controlador_pilha_if #(
    parameter int LARGURA = 16,
    parameter int ADDR_W  = 6
);
    logic               push;
    logic               pop;
    logic [LARGURA-1:0] din;
`ifdef PILHA_PEEK_EN
    logic               peek;
`endif
    logic               ready;
    logic [LARGURA-1:0] dout;
    logic               dout_valid;
    logic               full;
    logic               empty;
    logic [ADDR_W:0]    count;
    logic               overflow;
    logic               underflow;

    modport master (
        output push, pop, din,
`ifdef PILHA_PEEK_EN
        output peek,
`endif
        input  ready, dout, dout_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, din,
`ifdef PILHA_PEEK_EN
        input  peek,
`endif
        output ready, dout, dout_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/controlador_pilha.sv
// -----------------------------------------------------------------------------
// controlador_pilha
// Stack controller for a single-port, rising-edge, registered-read memory.
// Owns the stack pointer and turns push/pop requests into memory cycles.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pif          : datapath bundle (controlador_pilha_if.slave)
//   mem_data_io  : bidirectional memory data bus, driven only while writing
//   mem_end_o    : memory address, zero-extended stack slot
//   mem_io_o     : 1 = write (controller drives bus), 0 = read
// Optional macro PILHA_PEEK_EN: adds a peek request that reads the top of
// stack without changing sp/count.
// Timing: push occupies 2 cycles (IDLE accept + WR); pop/peek occupies 3 cycles
// (accept + RD1 + RD2) with dout_valid in the cycle after RD2.
// -----------------------------------------------------------------------------
module controlador_pilha #(
    parameter int LARGURA      = 16,
    parameter int PROFUNDIDADE = 64,
    parameter int ADDR_W       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    controlador_pilha_if.slave      pif,
    inout  wire  [LARGURA-1:0]      mem_data_io,
    output logic [LARGURA-1:0]      mem_end_o,
    output logic                    mem_io_o
);

    typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

    localparam logic [ADDR_W-1:0] SP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(PROFUNDIDADE);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mem_io_q, mem_io_d;
    logic [ADDR_W-1:0]   mem_end_q, mem_end_d;
    logic [LARGURA-1:0]  wdata_q, wdata_d;
    logic [LARGURA-1:0]  dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic full, empty;
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sp_q         <= '0;
            count_q      <= '0;
            mem_io_q     <= 1'b0;
            mem_end_q    <= '0;
            wdata_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            count_q      <= count_d;
            mem_io_q     <= mem_io_d;
            mem_end_q    <= mem_end_d;
            wdata_q      <= wdata_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sp_d         = sp_q;
        count_d      = count_q;
        mem_io_d     = 1'b0;       // write strobe lasts exactly the WR cycle
        mem_end_d    = mem_end_q;
        wdata_d      = wdata_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q;
        unf_d        = unf_q;

        case (state_q)
            IDLE: begin
                // A push while full still lets a simultaneous pop through.
                if (pif.push && full)
                    ovf_d = 1'b1;

                if (pif.push && !full) begin
                    mem_end_d = sp_q;
                    mem_io_d  = 1'b1;
                    wdata_d   = pif.din;
                    sp_d      = sp_q + SP_ONE;   // wraps to 0 on the last slot
                    count_d   = count_q + CNT_ONE;
                    state_d   = WR;
                end else if (pif.pop) begin
                    if (!empty) begin
                        mem_end_d = sp_q - SP_ONE;
                        sp_d      = sp_q - SP_ONE;
                        count_d   = count_q - CNT_ONE;
                        state_d   = RD1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
`ifdef PILHA_PEEK_EN
                else if (pif.peek) begin
                    if (!empty) begin
                        mem_end_d = sp_q - SP_ONE;
                        state_d   = RD1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
`endif
            end
            WR:  state_d = IDLE;
            RD1: state_d = RD2;       // memory registers the word at this edge
            RD2: begin
                dout_d       = mem_data_io;
                dout_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_io is registered, so the controller only drives after the memory
    // has seen the direction change.
    assign mem_data_io = mem_io_q ? wdata_q : {LARGURA{1'bz}};
    assign mem_end_o   = {{(LARGURA-ADDR_W){1'b0}}, mem_end_q};
    assign mem_io_o    = mem_io_q;

    assign pif.ready      = (state_q == IDLE);
    assign pif.dout       = dout_q;
    assign pif.dout_valid = dout_valid_q;
    assign pif.full       = full;
    assign pif.empty      = empty;
    assign pif.count      = count_q;
    assign pif.overflow   = ovf_q;
    assign pif.underflow  = unf_q;

endmodule

// File: doc/controlador_pilha.md
Name: controlador_pilha

Overview:
- Initiator/controller for the team's single-port stack memory (bidirectional data bus, address, `io` direction strobe, rising-edge memory).
- Owns the stack pointer and turns push/pop requests from the datapath into memory write/read cycles.
- Drives the shared data bus only during writes and captures registered read data from the memory.
- Reports full/empty, occupancy and overflow/underflow.

Parameters:
- LARGURA, 16, data and memory address bus width.
- PROFUNDIDADE, 64, stack depth in words.
- ADDR_W, 6, stack pointer width; PROFUNDIDADE = 2**ADDR_W.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- push  input  1  push request; sampled only when ready=1.
- pop  input  1  pop request; sampled only when ready=1.
- din  input  LARGURA  word to push; sampled with push.
- ready  output  1  high in IDLE only (decoded from state).
- dout  output  LARGURA  popped word; registered.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- full  output  1  count == PROFUNDIDADE.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  current occupancy.
- overflow  output  1  sticky; set by a push attempted while full.
- underflow  output  1  sticky; set by a pop attempted while empty.
- mem_data  inout  LARGURA  memory data bus.
- mem_end  output  LARGURA  memory address; zero-extended from ADDR_W bits.
- mem_io  output  1  1 = write (controller drives bus), 0 = read (memory drives bus).

Behaviour:
- Reset values: state IDLE, sp=0, count=0, mem_io=0, mem_end=0, dout=0, dout_valid=0, overflow=0, underflow=0, write data register=0.
- Clock/reset: one clock, `clk`. Reset is synchronous and active-high on `rst`, and has priority over everything.
- Bus ownership:
  - mem_data is driven with the write data register only while mem_io=1; otherwise it is high-Z.
  - mem_io is registered and changes only on clk, so both ends never drive the bus in the same cycle.
- FSM states: IDLE, WR, RD1, RD2.
- IDLE, accept rules at a rising edge:
  - push=1 and !full (push wins over a simultaneous pop): mem_end<=sp, mem_io<=1, wdata<=din, sp<=sp+1, count+1, go to WR.
  - push=1 and full: no memory cycle, overflow<=1. If pop is also 1, the pop is accepted as below.
  - pop=1 (push not accepted) and !empty: mem_end<=sp-1, mem_io<=0, sp<=sp-1, count-1, go to RD1.
  - pop=1 and empty: underflow<=1, stay in IDLE.
- WR: memory stores mem_data at the edge ending WR. At that edge mem_io<=0 and the FSM returns to IDLE. Push occupancy is 2 cycles.
- RD1: memory registers the word at mem_end at the edge ending RD1. Go to RD2.
- RD2: memory drives mem_data. At the edge ending RD2: dout<=mem_data, dout_valid<=1 for exactly one cycle, go to IDLE.
- Pop latency: dout_valid is high in the 3rd cycle after the accepting edge. Pop occupancy is 3 cycles.
- While ready=0, push and pop are ignored, not queued. The requester holds its request until ready=1.
- Count arithmetic:
  - Stored count width ADDR_W+1; full when count == PROFUNDIDADE, without wrap.
  - sp is ADDR_W bits. Pushing into the last slot makes sp wrap 63->0 while count=64; sp-1 then correctly addresses slot 63.
- dout holds its value between pops.
- overflow and underflow clear only on rst.
- Reset mid-operation:
  - FSM returns to IDLE and mem_io=0 on the reset edge.
  - A write whose WR cycle ends on the reset edge still lands in memory (the memory has no reset), but sp/count are cleared, so that content is dead.
  - A read in flight produces no dout_valid.

Optional Feature:
- PILHA_PEEK_EN
- Defined:
  - Adds input `peek` (1 bit), sampled in IDLE with the lowest priority (below push and pop).
  - If !empty, it runs the RD1/RD2 sequence at address sp-1 with sp and count unchanged, and produces dout/dout_valid with the same 3-cycle latency.
  - Peek while empty sets underflow.
- Undefined: no `peek` port exists and the FSM has no peek path.

Test Plan:
- Reset then idle: rst high 2 cycles -> count=0, empty=1, full=0, mem_io=0, mem_data high-Z from controller, ready=1.
- Push 0x1234, push 0xABCD, pop, pop -> mem_io=1 one cycle each at mem_end=0 then 1. Pops read mem_end=1 then 0; dout=0xABCD then 0x1234, each dout_valid 3 cycles after its accepting edge; empty=1 at the end.
- Push 64 words (value = index) -> full=1, count=64. A 65th push sets overflow=1 with no mem_io=1 cycle. Pop returns 63.
- Pop when empty -> underflow=1, no state change, no dout_valid. Simultaneous push+pop with 1 entry -> push taken, count=2.
- Assert rst during RD1 of a pop -> no dout_valid, count=0, state IDLE next cycle.
- With PILHA_PEEK_EN: push 0x5555, peek -> dout=0x5555 with dout_valid, count stays 1. A following pop returns 0x5555.
